lfsr_prbs_checker: RTL and testbench

LFSR_PRBS_CHECKER -- requirements
Module: lfsr_prbs_checker

---
 rtl/lfsr_pkg.sv | 30 +++
 rtl/sat_counter.sv | 47 ++++
 rtl/lfsr_prbs_checker.sv | 132 +++++++++++++
 tb/tb_lfsr_prbs_checker.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Items shared by the PRBS checker and any PRBS generator:
//   LFSR_W        - length of the sequence history (64 bits)
//   TAP_*         - feedback tap indices into the history (h[0] = newest bit)
//   chk_state_e   - checker FSM states (LOAD while filling, CHECK while locked)
//   lfsr_next_bit - next bit of the 64-bit XNOR Fibonacci sequence
// -----------------------------------------------------------------------------
package lfsr_pkg;

   localparam int LFSR_W = 64;

   localparam int TAP_A = 63;
   localparam int TAP_B = 62;
   localparam int TAP_C = 60;
   localparam int TAP_D = 59;

   typedef enum logic {
      LOAD  = 1'b0,
      CHECK = 1'b1
   } chk_state_e;

   // XNOR feedback keeps all-zeros reachable and makes all-ones the lock-up
   // state; an all-ones history predicts another one, so a constant-ones
   // stream is self-consistent.
   function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] hist);
      return ~(hist[TAP_A] ^ hist[TAP_B] ^ hist[TAP_C] ^ hist[TAP_D]);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear that takes priority over
// increment.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset, forces count to zero
//   clr   - synchronous clear (wins over inc)
//   inc   - increment by one unless already all-ones
//   count - current count value
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   // Next count: clear first, otherwise step up until every bit is set and
   // then hold there.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/lfsr_prbs_checker.sv
// -----------------------------------------------------------------------------
// lfsr_prbs_checker
// Locks onto a 64-bit XNOR Fibonacci PRBS stream and counts bit errors.
// The first 64 valid bits fill the history (LOAD); afterwards each valid bit is
// compared with the predicted bit (CHECK). The history is advanced with the
// predicted bit, not the received one, so a single corrupted bit is counted
// once instead of propagating through the taps. LOSS_THRESH consecutive
// mismatches drop lock and restart the fill.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   bit_valid  - bit_in is presented this cycle
//   bit_in     - received PRBS bit, oldest first
//   clr_count  - synchronous clear of err_count
//   locked     - checker is synchronised (state CHECK)
//   err_strobe - one-cycle pulse per counted mismatch
//   err_count  - saturating count of mismatches seen while locked
// -----------------------------------------------------------------------------
module lfsr_prbs_checker
   import lfsr_pkg::*;
#(
   parameter int LOSS_THRESH = 8,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit_valid,
   input  logic             bit_in,
   input  logic             clr_count,
   output logic             locked,
   output logic             err_strobe,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [7:0] THRESH    = 8'(LOSS_THRESH);
   localparam logic [6:0] FILL_LAST = 7'(LFSR_W - 1);

   chk_state_e        state_d, state_q;
   logic [LFSR_W-1:0] hist_d, hist_q;
   logic [6:0]        fill_d, fill_q;
   logic [7:0]        run_d, run_q;
   logic              locked_d, locked_q;
   logic              err_strobe_d, err_strobe_q;

   logic              predicted;
   logic [7:0]        run_next;
   logic              count_inc;

   // Next-state logic. Nothing moves unless a bit is offered; the strobe
   // defaults low so it only ever lasts one cycle. In LOAD the received bit
   // fills the history and the 64th bit switches to CHECK. In CHECK a
   // mismatch is counted and extends the run of consecutive mismatches; the
   // run reaching LOSS_THRESH falls back to LOAD with a fresh fill.
   always_comb begin
      state_d      = state_q;
      hist_d       = hist_q;
      fill_d       = fill_q;
      run_d        = run_q;
      err_strobe_d = 1'b0;
      count_inc    = 1'b0;
      predicted    = lfsr_next_bit(hist_q);
      run_next     = run_q + 8'd1;

      if (bit_valid) begin
         case (state_q)
            LOAD: begin
               hist_d = {hist_q[LFSR_W-2:0], bit_in};
               fill_d = fill_q + 7'd1;
               if (fill_q == FILL_LAST) begin
                  state_d = CHECK;
               end
            end
            CHECK: begin
               hist_d = {hist_q[LFSR_W-2:0], predicted};
               if (bit_in != predicted) begin
                  err_strobe_d = 1'b1;
                  count_inc    = 1'b1;
                  run_d        = run_next;
                  if (run_next == THRESH) begin
                     state_d = LOAD;
                     fill_d  = 7'd0;
                     run_d   = 8'd0;
                  end
               end else begin
                  run_d = 8'd0;
               end
            end
            default: begin
               state_d = LOAD;
            end
         endcase
      end

      locked_d = (state_d == CHECK);
   end

   // All checker state, including the registered locked and err_strobe
   // outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= LOAD;
         hist_q       <= '0;
         fill_q       <= 7'd0;
         run_q        <= 8'd0;
         locked_q     <= 1'b0;
         err_strobe_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hist_q       <= hist_d;
         fill_q       <= fill_d;
         run_q        <= run_d;
         locked_q     <= locked_d;
         err_strobe_q <= err_strobe_d;
      end
   end

   // Error counter increments on the same edge that raises err_strobe; a
   // coincident clr_count leaves it at zero.
   sat_counter #(
      .WIDTH (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst   (reset),
      .clr   (clr_count),
      .inc   (count_inc),
      .count (err_count)
   );

   assign locked     = locked_q;
   assign err_strobe = err_strobe_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_prbs_checker
// Drives a reference PRBS stream into two checkers (32-bit and 4-bit error
// counters) and compares lock timing, strobes and counts with expected values.
// -----------------------------------------------------------------------------
module tb_lfsr_prbs_checker;

   localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        bit_valid;
   logic        bit_in;
   logic        clr_count;
   logic        locked;
   logic        err_strobe;
   logic [31:0] err_count;
   logic        locked_s;
   logic        err_strobe_s;
   logic [3:0]  err_count_s;

   int          checks = 0;
   int          errors = 0;

   logic [63:0] gen;
   int          strobes;
   int          strobes_s;
   int          first_strobe;
   int          lock_rise;
   int          unlock_at;
   int          idle_strobes;

   always #5 clk = ~clk;

   lfsr_prbs_checker #(
      .LOSS_THRESH (8),
      .CNT_W       (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .clr_count  (clr_count),
      .locked     (locked),
      .err_strobe (err_strobe),
      .err_count  (err_count)
   );

   lfsr_prbs_checker #(
      .LOSS_THRESH (8),
      .CNT_W       (4)
   ) dut_small (
      .clk        (clk),
      .reset      (reset),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .clr_count  (clr_count),
      .locked     (locked_s),
      .err_strobe (err_strobe_s),
      .err_count  (err_count_s)
   );

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Reference generator, h[0] newest.
   task automatic gen_bit(output logic b);
      b   = ~(gen[63] ^ gen[62] ^ gen[60] ^ gen[59]);
      gen = {gen[62:0], b};
   endtask

   // One bit, optionally preceded by an idle cycle; samples 1 time unit after
   // the accepting edge.
   task automatic applyStimulus(input logic b, input bit gap);
      if (gap) begin
         bit_valid = 1'b0;
         @(posedge clk);
         #1;
         if (err_strobe) idle_strobes++;
      end
      bit_valid = 1'b1;
      bit_in    = b;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
   endtask

   // Sends n generator bits; bits inv_a, inv_a+period, ... below inv_b are
   // inverted. Records strobe count, first strobe index and lock transitions.
   task automatic send_stream(input int n, input int inv_a, input int inv_b,
                              input int period, input bit gap);
      logic b;
      logic prev;
      strobes      = 0;
      strobes_s    = 0;
      first_strobe = -1;
      lock_rise    = -1;
      unlock_at    = -1;
      idle_strobes = 0;
      prev         = locked;
      for (int i = 0; i < n; i++) begin
         gen_bit(b);
         if (i >= inv_a && i < inv_b && ((i - inv_a) % period) == 0) b = ~b;
         applyStimulus(b, gap);
         if (err_strobe) begin
            strobes++;
            if (first_strobe < 0) first_strobe = i;
         end
         if (err_strobe_s) strobes_s++;
         if (locked && !prev && lock_rise < 0) lock_rise = i;
         if (!locked && prev && unlock_at < 0) unlock_at = i;
         prev = locked;
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      clr_count = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      gen   = SEED;
   endtask

   initial begin
      reset     = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      clr_count = 1'b0;
      gen       = SEED;
      #2;
      reset = 1'b1;
      #2;
      checkOutput("rst_locked", int'(locked), 0);
      checkOutput("rst_strobe", int'(err_strobe), 0);
      checkOutput("rst_count", int'(err_count), 0);
      checkOutput("rst_count_small", int'(err_count_s), 0);

      $display("[TB] clean stream");
      do_reset();
      send_stream(200, -1, -1, 1, 1'b0);
      checkOutput("clean_lock_idx", lock_rise, 63);
      checkOutput("clean_strobes", strobes, 0);
      checkOutput("clean_count", int'(err_count), 0);
      checkOutput("clean_locked", int'(locked), 1);

      $display("[TB] single error at bit 100");
      do_reset();
      send_stream(200, 99, 100, 1, 1'b0);
      checkOutput("single_lock_idx", lock_rise, 63);
      checkOutput("single_strobes", strobes, 1);
      checkOutput("single_strobe_idx", first_strobe, 99);
      checkOutput("single_count", int'(err_count), 1);
      checkOutput("single_locked", int'(locked), 1);
      checkOutput("single_unlock", unlock_at, -1);

      $display("[TB] burst of 8 errors");
      do_reset();
      send_stream(100, -1, -1, 1, 1'b0);
      checkOutput("burst_pre_locked", int'(locked), 1);
      send_stream(8, 0, 8, 1, 1'b0);
      checkOutput("burst_strobes", strobes, 8);
      checkOutput("burst_unlock_idx", unlock_at, 7);
      checkOutput("burst_count", int'(err_count), 8);
      send_stream(64, -1, -1, 1, 1'b0);
      checkOutput("burst_relock_idx", lock_rise, 63);
      checkOutput("burst_relock_strobes", strobes, 0);
      checkOutput("burst_relock_count", int'(err_count), 8);

      $display("[TB] saturation and clear");
      do_reset();
      send_stream(70, -1, -1, 1, 1'b0);
      send_stream(80, 0, 80, 4, 1'b0);
      checkOutput("sat_strobes", strobes, 20);
      checkOutput("sat_strobes_small", strobes_s, 20);
      checkOutput("sat_count", int'(err_count), 20);
      checkOutput("sat_count_small", int'(err_count_s), 15);
      checkOutput("sat_locked", int'(locked), 1);
      clr_count = 1'b1;
      send_stream(1, 0, 1, 1, 1'b0);
      clr_count = 1'b0;
      checkOutput("clr_count", int'(err_count), 0);
      checkOutput("clr_count_small", int'(err_count_s), 0);
      checkOutput("clr_strobes", strobes, 1);
      checkOutput("clr_locked", int'(locked), 1);
      send_stream(3, 0, 1, 1, 1'b0);
      checkOutput("post_clr_count", int'(err_count), 1);
      checkOutput("post_clr_count_small", int'(err_count_s), 1);

      $display("[TB] gapped stream with reset at bit 150");
      do_reset();
      send_stream(150, 99, 150, 50, 1'b1);
      checkOutput("gap_lock_idx", lock_rise, 63);
      checkOutput("gap_strobes", strobes, 2);
      checkOutput("gap_strobe_idx", first_strobe, 99);
      checkOutput("gap_count", int'(err_count), 2);
      checkOutput("gap_idle_strobes", idle_strobes, 0);
      checkOutput("gap_strobe_live", int'(err_strobe), 1);
      checkOutput("gap_locked", int'(locked), 1);
      reset = 1'b1;
      #1;
      checkOutput("midrst_locked", int'(locked), 0);
      checkOutput("midrst_strobe", int'(err_strobe), 0);
      checkOutput("midrst_count", int'(err_count), 0);
      checkOutput("midrst_count_small", int'(err_count_s), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      send_stream(64, -1, -1, 1, 1'b1);
      checkOutput("midrst_relock_idx", lock_rise, 63);
      checkOutput("midrst_relock_strobes", strobes, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
